// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store stage: access sizes, FSM states,
// byte-enable patterns and the bus-lane helpers used when a request is accepted.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Size 2'b11 is treated as a word everywhere.
    function automatic logic is_word(input logic [1:0] size);
        return size[1];
    endfunction

    function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] be;
        if (is_word(size)) begin
            be = BE_WORD;
        end else if (size == SZ_HALF) begin
            be = lo[1] ? BE_HALF_HI : BE_HALF_LO;
        end else begin
            be = BE_BYTE << lo;
        end
        return be;
    endfunction

    function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] sd);
        logic [31:0] wd;
        if (is_word(size)) begin
            wd = sd;
        end else if (size == SZ_HALF) begin
            wd = {2{sd[15:0]}};
        end else begin
            wd = {4{sd[7:0]}};
        end
        return wd;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// Picks the addressed byte/halfword lane out of a bus word and extends it.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane select followed by sign or zero extension; words pass untouched.
    always_comb begin
        unique case (addr_lo_i)
            2'd0:    byte_lane = rdata_i[7:0];
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            default: byte_lane = rdata_i[31:24];
        endcase
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        if (is_word(size_i)) begin
            data_o = rdata_i;
        end else if (size_i == SZ_HALF) begin
            data_o = {{16{signed_i & half_lane[15]}}, half_lane};
        end else begin
            data_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one req/ack transaction per access, stalls the core while
// outstanding, aborts with bus_err after TIMEOUT cycles without an ack.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for a valid request; stall asserted combinationally
//   REQ     | bus_req high, waiting for bus_ack or the timeout
//   DONE    | result (read_data/bus_err) valid, stall low for one cycle
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [1:0]  size_i,
    input  logic        load_signed_i,
    output logic [31:0] read_data_o,
    output logic        stall_o,
    output logic        addr_err_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    mem_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic              bus_we_q, bus_we_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        lo_q, lo_d;
    logic [31:0]       read_data_q, read_data_d;
    logic              bus_err_q, bus_err_d;

    logic              req_any;
    logic              misalign;
    logic              req_valid;
    logic [31:0]       aligned_data;

    load_aligner u_load_aligner (
        .rdata_i   (bus_rdata_i),
        .addr_lo_i (lo_q),
        .size_i    (size_q),
        .signed_i  (sign_q),
        .data_o    (aligned_data)
    );

    // Misalignment check; a trapped access never reaches the FSM.
    always_comb begin
        req_any    = mem_read_i | mem_write_i;
        misalign   = ((size_i == SZ_HALF) & addr_i[0]) |
                     (is_word(size_i) & (addr_i[1:0] != 2'b00));
        addr_err_o = req_any & misalign;
        req_valid  = req_any & ~misalign;
    end

    // Next-state, request latching, timeout counting and result capture.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        bus_we_d    = bus_we_q;
        size_d      = size_q;
        sign_d      = sign_q;
        lo_d        = lo_q;
        read_data_d = read_data_q;
        bus_err_d   = bus_err_q;
        stall_o     = 1'b0;
        bus_req_o   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    stall_o     = 1'b1;
                    bus_addr_d  = {addr_i[31:2], 2'b00};
                    bus_we_d    = mem_write_i;
                    bus_be_d    = calc_be(size_i, addr_i[1:0]);
                    bus_wdata_d = calc_wdata(size_i, store_data_i);
                    size_d      = size_i;
                    sign_d      = load_signed_i;
                    lo_d        = addr_i[1:0];
                    cnt_d       = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                bus_req_o = 1'b1;
                stall_o   = 1'b1;
                // Ack is checked first so an ack on the timeout edge still succeeds.
                if (bus_ack_i) begin
                    if (!bus_we_q) begin
                        read_data_d = aligned_data;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    bus_err_d   = 1'b1;
                    read_data_d = '0;
                    state_d     = ST_DONE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                bus_err_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= BE_NONE;
            bus_we_q    <= 1'b0;
            size_q      <= SZ_BYTE;
            sign_q      <= 1'b0;
            lo_q        <= 2'b00;
            read_data_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            bus_we_q    <= bus_we_d;
            size_q      <= size_d;
            sign_q      <= sign_d;
            lo_q        <= lo_d;
            read_data_q <= read_data_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign read_data_o = read_data_q;
    assign bus_err_o   = bus_err_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_be_o    = bus_be_q;

endmodule
